// File: rtl/key_counter_pkg.sv
// Shared constants and count-update rule for the key_counter push-button front end.
package key_counter_pkg;

   localparam int DEF_DEBOUNCE_CYCLES = 1000000;
   localparam int DEF_SCAN_DIV        = 100000;

   localparam int NUM_BTN = 3;
   localparam int IDX_INC = 0;
   localparam int IDX_DEC = 1;
   localparam int IDX_CLR = 2;

   typedef logic [NUM_BTN-1:0] btn_vec_t;

   // clr dominates; inc and dec together cancel out.
   function automatic logic [7:0] next_value(input logic [7:0] cur,
                                              input btn_vec_t   p,
                                              input logic [7:0] init);
      logic [7:0] nv;
      nv = cur;
      if (p[IDX_CLR])                  nv = init;
      else if (p[IDX_INC] && p[IDX_DEC]) nv = cur;
      else if (p[IDX_INC])             nv = cur + 8'd1;
      else if (p[IDX_DEC])             nv = cur - 8'd1;
      return nv;
   endfunction

endpackage

// File: rtl/key_debounce.sv
// One button: two-flop synchronizer, hold-time debounce and a one-cycle press pulse.
module key_debounce
   import key_counter_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
   input  logic clk,
   input  logic rst_n,
   input  logic btn_raw,
   output logic level,
   output logic press
);

   localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic [1:0]    sync;
   logic          s;
   logic          st;
   logic          st_d;
   logic [CW-1:0] cnt;

   assign s     = sync[1];
   assign level = st;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync  <= '0;
         st    <= 1'b0;
         st_d  <= 1'b0;
         cnt   <= '0;
         press <= 1'b0;
      end else begin
         sync <= {sync[0], btn_raw};
         // Any sample matching the stable level restarts the hold interval.
         if (s == st) begin
            cnt <= '0;
         end else if (cnt == CNT_LAST) begin
            st  <= s;
            cnt <= '0;
         end else begin
            cnt <= cnt + 1'b1;
         end
         st_d  <= st;
         press <= st & ~st_d;
      end
   end

endmodule

// File: rtl/key_counter.sv
// Three debounced buttons driving an 8-bit up/down/clear count, plus the scanner's pacing tick.
module key_counter
   import key_counter_pkg::*;
#(
   parameter int         DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter int         SCAN_DIV        = DEF_SCAN_DIV,
   parameter logic [7:0] INIT_VALUE      = 8'h00
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 btn_inc,
   input  logic                 btn_dec,
   input  logic                 btn_clr,
   output logic [7:0]           data,
   output logic                 scan_tick,
   output logic [NUM_BTN-1:0]   press
);

   localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);

   btn_vec_t      btn_raw;
   btn_vec_t      btn_level;
   logic [DW-1:0] div;

   assign btn_raw[IDX_INC] = btn_inc;
   assign btn_raw[IDX_DEC] = btn_dec;
   assign btn_raw[IDX_CLR] = btn_clr;

   for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
      key_debounce #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
      ) u_deb (
         .clk     (clk),
         .rst_n   (rst_n),
         .btn_raw (btn_raw[i]),
         .level   (btn_level[i]),
         .press   (press[i])
      );
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) data <= INIT_VALUE;
      else        data <= next_value(data, press, INIT_VALUE);
   end

   // Free-running divider; the tick lands one cycle after the terminal count.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div       <= '0;
         scan_tick <= 1'b0;
      end else begin
         div       <= (div == DIV_LAST) ? '0 : div + 1'b1;
         scan_tick <= (div == DIV_LAST);
      end
   end

endmodule
